// File: rtl/des_block_engine_if.sv
// Host, block-RAM and DES-core signals of the DES block sequencer.
// master is the environment side (host, RAMs, core); slave is the engine.
interface des_block_engine_if #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = ADDR_W
);
    logic              start;
    logic              abort;
    logic              decrypt;
    logic              cbc;
    logic [63:0]       iv;
    logic [CNT_W-1:0]  num_blocks;
    logic [ADDR_W-1:0] ramI_addr;
    logic [31:0]       ramI_dout;
    logic [ADDR_W-1:0] ramO_addr;
    logic [31:0]       ramO_din;
    logic              ramO_we;
    logic [63:0]       des_in;
    logic [3:0]        des_round;
    logic              des_decrypt;
    logic [63:0]       des_out;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  blocks_done;

    modport master (
        output start, abort, decrypt, cbc, iv, num_blocks, ramI_dout, des_out,
        input  ramI_addr, ramO_addr, ramO_din, ramO_we, des_in, des_round,
               des_decrypt, busy, done, blocks_done
    );

    modport slave (
        input  start, abort, decrypt, cbc, iv, num_blocks, ramI_dout, des_out,
        output ramI_addr, ramO_addr, ramO_din, ramO_we, des_in, des_round,
               des_decrypt, busy, done, blocks_done
    );
endinterface

// File: rtl/des_block_engine.sv
// DES block sequencer: fetches 64-bit blocks as two 32-bit words, steps an external
// 16-round DES core, and writes results back as two words, with ECB/CBC chaining.
module des_block_engine #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = ADDR_W
) (
    input  logic              clk1,
    input  logic              reset,
    des_block_engine_if.slave bus
);

    localparam int DEPTH = 2 ** (ADDR_W - 1);
    localparam int NW    = ((CNT_W > ADDR_W) ? CNT_W : ADDR_W) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LD0, S_LD1, S_LD2, S_RND, S_WR0, S_WR1, S_NXT, S_DONE
    } state_t;

    // A zero request means a full-depth run; oversize requests clamp to the depth.
    function automatic logic [NW-1:0] sat_blocks(input logic [CNT_W-1:0] n);
        logic [NW-1:0] n_w;
        n_w = NW'(n);
        if (n_w == '0 || n_w > NW'(DEPTH))
            return NW'(DEPTH);
        return n_w;
    endfunction

    state_t            state_q, state_d;
    logic              dec_q, dec_d;
    logic              cbc_q, cbc_d;
    logic [NW-1:0]     n_q, n_d;
    logic [63:0]       chain_q, chain_d;
    logic [63:0]       des_in_q, des_in_d;
    logic [3:0]        round_q, round_d;
    logic [ADDR_W-1:0] ramI_addr_q, ramI_addr_d;
    logic [ADDR_W-1:0] ramO_addr_q, ramO_addr_d;
    logic [CNT_W-1:0]  bdone_q, bdone_d;
    logic [31:0]       lo_q, lo_d;
    logic [63:0]       blk_q, blk_d;
    logic [63:0]       res_q, res_d;

    assign bus.ramI_addr   = ramI_addr_q;
    assign bus.ramO_addr   = ramO_addr_q;
    assign bus.des_in      = des_in_q;
    assign bus.des_round   = round_q;
    assign bus.des_decrypt = dec_q;
    assign bus.blocks_done = bdone_q;

    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.ramO_we  = 1'b0;
        bus.ramO_din = '0;
        case (state_q)
            S_LD0, S_LD1, S_LD2, S_RND, S_NXT: bus.busy = 1'b1;
            S_WR0: begin
                bus.busy     = 1'b1;
                bus.ramO_we  = 1'b1;
                bus.ramO_din = res_q[31:0];
            end
            S_WR1: begin
                bus.busy     = 1'b1;
                bus.ramO_we  = 1'b1;
                bus.ramO_din = res_q[63:32];
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        dec_d       = dec_q;
        cbc_d       = cbc_q;
        n_d         = n_q;
        chain_d     = chain_q;
        des_in_d    = des_in_q;
        round_d     = round_q;
        ramI_addr_d = ramI_addr_q;
        ramO_addr_d = ramO_addr_q;
        bdone_d     = bdone_q;
        lo_d        = lo_q;
        blk_d       = blk_q;
        res_d       = res_q;
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d     = S_LD0;
                        dec_d       = bus.decrypt;
                        cbc_d       = bus.cbc;
                        chain_d     = bus.iv;
                        n_d         = sat_blocks(bus.num_blocks);
                        ramI_addr_d = '0;
                        ramO_addr_d = '0;
                        bdone_d     = '0;
                    end
                end
                S_LD0: begin
                    ramI_addr_d = ramI_addr_q + ADDR_W'(1);
                    state_d     = S_LD1;
                end
                S_LD1: begin
                    lo_d        = bus.ramI_dout;
                    ramI_addr_d = ramI_addr_q + ADDR_W'(1);
                    state_d     = S_LD2;
                end
                S_LD2: begin
                    blk_d    = {bus.ramI_dout, lo_q};
                    des_in_d = {bus.ramI_dout, lo_q} ^ ((cbc_q && !dec_q) ? chain_q : 64'd0);
                    round_d  = 4'd0;
                    state_d  = S_RND;
                end
                S_RND: begin
                    if (round_q == 4'd15) begin
                        res_d = bus.des_out ^ ((cbc_q && dec_q) ? chain_q : 64'd0);
                        // Decrypt chains on the raw ciphertext, encrypt on the core result.
                        if (cbc_q)
                            chain_d = dec_q ? blk_q : bus.des_out;
                        state_d = S_WR0;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
                S_WR0: begin
                    ramO_addr_d = ramO_addr_q + ADDR_W'(1);
                    state_d     = S_WR1;
                end
                S_WR1: begin
                    ramO_addr_d = ramO_addr_q + ADDR_W'(1);
                    state_d     = S_NXT;
                end
                S_NXT: begin
                    bdone_d = bdone_q + CNT_W'(1);
                    if (NW'(bdone_q) + NW'(1) == n_q)
                        state_d = S_DONE;
                    else
                        state_d = S_LD0;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dec_q       <= 1'b0;
            cbc_q       <= 1'b0;
            n_q         <= '0;
            chain_q     <= '0;
            des_in_q    <= '0;
            round_q     <= '0;
            ramI_addr_q <= '0;
            ramO_addr_q <= '0;
            bdone_q     <= '0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            cbc_q       <= cbc_d;
            n_q         <= n_d;
            chain_q     <= chain_d;
            des_in_q    <= des_in_d;
            round_q     <= round_d;
            ramI_addr_q <= ramI_addr_d;
            ramO_addr_q <= ramO_addr_d;
            bdone_q     <= bdone_d;
        end
    end

    // Block holding registers only carry data; control decides when they matter.
    always_ff @(posedge clk1) begin
        lo_q  <= lo_d;
        blk_q <= blk_d;
        res_q <= res_d;
    end

endmodule

// File: tb/tb_des_block_engine.sv
// Directed bench for des_block_engine with behavioural RAMs and a stand-in DES core
// that returns the FIPS pair exactly and an invertible toy cipher for other blocks.
module tb_des_block_engine;

    localparam int ADDR_W = 9;
    localparam int CNT_W  = 9;
    localparam logic [63:0] FIPS_PT = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] FIPS_CT = 64'h85E8_1354_0F0A_B405;
    localparam logic [63:0] TOY_K   = 64'hA5A5_0F0F_3C3C_5A5A;

    logic clk1 = 1'b0;
    logic reset;
    always #5 clk1 = ~clk1;

    des_block_engine_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    des_block_engine #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [31:0] mem_i [0:511];
    logic [31:0] mem_o [0:511];
    int          we_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [63:0] toy_enc(input logic [63:0] x);
        return {x[50:0], x[63:51]} ^ TOY_K;
    endfunction

    function automatic logic [63:0] toy_dec(input logic [63:0] y);
        logic [63:0] t;
        t = y ^ TOY_K;
        return {t[12:0], t[63:13]};
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] x, input logic dec);
        if (!dec) return (x == FIPS_PT) ? FIPS_CT : toy_enc(x);
        return (x == FIPS_CT) ? FIPS_PT : toy_dec(x);
    endfunction

    // Core result is only meaningful in the last round.
    always_comb
        bus.des_out = (bus.des_round == 4'd15) ? des_model(bus.des_in, bus.des_decrypt)
                                               : 64'hBAD0_BAD0_BAD0_BAD0;

    always @(posedge clk1) begin
        bus.ramI_dout <= mem_i[bus.ramI_addr];
        if (bus.ramO_we) begin
            mem_o[bus.ramO_addr] <= bus.ramO_din;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic dec, input logic cbcm, input logic [63:0] ivv,
                             input logic [CNT_W-1:0] n);
        @(negedge clk1);
        bus.decrypt    = dec;
        bus.cbc        = cbcm;
        bus.iv         = ivv;
        bus.num_blocks = n;
        bus.start      = 1'b1;
        @(negedge clk1);
        bus.start   = 1'b0;
        bus.decrypt = ~dec;
        bus.cbc     = ~cbcm;
        bus.iv      = {$urandom, $urandom};
        check_val("busy after start", 64'(bus.busy), 64'd1);
        check_val("des_decrypt latched", 64'(bus.des_decrypt), 64'(dec));
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 1;
        while (bus.done !== 1'b1 && cycles < 6000) begin
            @(negedge clk1);
            cycles++;
        end
        check_val({tag, " done"}, 64'(bus.done), 64'd1);
        check_val({tag, " busy in DONE"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int          cyc;
        int          base;
        int          wait_cyc;
        logic        seen_done;
        logic [63:0] c0, c1, c2;

        bus.start = 1'b0;  bus.abort = 1'b0;  bus.decrypt = 1'b0;  bus.cbc = 1'b0;
        bus.iv = '0;       bus.num_blocks = '0;
        for (int i = 0; i < 512; i++) mem_i[i] = 32'h1000_0000 + i;
        reset = 1'b1;
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        check_val("reset busy", 64'(bus.busy), 64'd0);
        check_val("reset done", 64'(bus.done), 64'd0);
        check_val("reset ramO_we", 64'(bus.ramO_we), 64'd0);
        check_val("reset blocks_done", 64'(bus.blocks_done), 64'd0);
        check_val("reset addrs", 64'({bus.ramI_addr, bus.ramO_addr}), 64'd0);
        check_val("reset des_in", bus.des_in, 64'd0);
        check_val("reset round/dec/din", 64'({bus.des_round, bus.des_decrypt, bus.ramO_din}), 64'd0);
        reset = 1'b0;

        // FIPS ECB encrypt, one block
        mem_i[0] = 32'h89AB_CDEF;  mem_i[1] = 32'h0123_4567;
        start_run(1'b0, 1'b0, 64'd0, 9'd1);
        wait_done("ecb enc", cyc);
        check_val("ecb enc latency", 64'(cyc), 64'd23);
        @(negedge clk1);
        check_val("ecb enc word0", 64'(mem_o[0]), 64'h0F0A_B405);
        check_val("ecb enc word1", 64'(mem_o[1]), 64'h85E8_1354);
        check_val("ecb enc blocks_done", 64'(bus.blocks_done), 64'd1);

        // ECB decrypt of the ciphertext
        mem_i[0] = 32'h0F0A_B405;  mem_i[1] = 32'h85E8_1354;
        start_run(1'b1, 1'b0, 64'd0, 9'd1);
        wait_done("ecb dec", cyc);
        @(negedge clk1);
        check_val("ecb dec word0", 64'(mem_o[0]), 64'h89AB_CDEF);
        check_val("ecb dec word1", 64'(mem_o[1]), 64'h0123_4567);
        check_val("ecb dec blocks_done", 64'(bus.blocks_done), 64'd1);

        // CBC encrypt of three identical blocks, IV 0
        for (int b = 0; b < 3; b++) begin
            mem_i[2*b] = FIPS_PT[31:0];  mem_i[2*b+1] = FIPS_PT[63:32];
        end
        start_run(1'b0, 1'b1, 64'd0, 9'd3);
        wait_done("cbc enc", cyc);
        check_val("cbc enc latency", 64'(cyc), 64'd67);
        @(negedge clk1);
        c0 = {mem_o[1], mem_o[0]};  c1 = {mem_o[3], mem_o[2]};  c2 = {mem_o[5], mem_o[4]};
        check_val("cbc c0", c0, FIPS_CT);
        check_val("cbc c1", c1, toy_enc(FIPS_PT ^ FIPS_CT));
        check_val("cbc c2", c2, toy_enc(FIPS_PT ^ toy_enc(FIPS_PT ^ FIPS_CT)));
        check_val("cbc c1 distinct", 64'(c1 != c0 && c2 != c1 && c2 != c0), 64'd1);
        check_val("cbc enc blocks_done", 64'(bus.blocks_done), 64'd3);

        // CBC decrypt restores the plaintext
        for (int i = 0; i < 6; i++) mem_i[i] = mem_o[i];
        start_run(1'b1, 1'b1, 64'd0, 9'd3);
        wait_done("cbc dec", cyc);
        @(negedge clk1);
        for (int b = 0; b < 3; b++)
            check_val($sformatf("cbc dec block%0d", b), {mem_o[2*b+1], mem_o[2*b]}, FIPS_PT);
        check_val("cbc dec blocks_done", 64'(bus.blocks_done), 64'd3);

        // Full-depth run via num_blocks = 0
        for (int i = 0; i < 512; i++) mem_i[i] = 32'h1000_0000 + i;
        base = we_cnt;
        start_run(1'b0, 1'b0, 64'd0, 9'd0);
        wait_done("full", cyc);
        check_val("full latency", 64'(cyc), 64'd5633);
        check_val("full blocks_done", 64'(bus.blocks_done), 64'd256);
        check_val("full ramO_addr wrap", 64'(bus.ramO_addr), 64'd0);
        @(negedge clk1);
        check_val("full write count", 64'(we_cnt - base), 64'd512);
        check_val("full block0", {mem_o[1], mem_o[0]}, toy_enc({mem_i[1], mem_i[0]}));
        check_val("full block255", {mem_o[511], mem_o[510]}, toy_enc({mem_i[511], mem_i[510]}));

        // Oversize request clamps to depth
        start_run(1'b0, 1'b0, 64'd0, 9'd300);
        wait_done("sat", cyc);
        check_val("sat latency", 64'(cyc), 64'd5633);
        check_val("sat blocks_done", 64'(bus.blocks_done), 64'd256);

        // Abort during block 2, round 7
        base = we_cnt;
        start_run(1'b0, 1'b0, 64'd0, 9'd4);
        wait_cyc = 0;
        while (!(bus.blocks_done == 9'd2 && bus.des_round == 4'd7 && bus.busy) && wait_cyc < 200) begin
            @(negedge clk1);
            wait_cyc++;
        end
        check_val("abort reach round7", 64'(bus.des_round), 64'd7);
        bus.abort = 1'b1;
        @(negedge clk1);
        bus.abort = 1'b0;
        check_val("abort busy", 64'(bus.busy), 64'd0);
        check_val("abort done", 64'(bus.done), 64'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk1);
            if (bus.done || bus.ramO_we) seen_done = 1'b1;
        end
        check_val("abort quiet after", 64'(seen_done), 64'd0);
        check_val("abort writes", 64'(we_cnt - base), 64'd4);
        check_val("abort blocks_done", 64'(bus.blocks_done), 64'd2);

        mem_i[0] = 32'h89AB_CDEF;  mem_i[1] = 32'h0123_4567;
        start_run(1'b0, 1'b0, 64'd0, 9'd1);
        wait_done("post-abort", cyc);
        check_val("post-abort latency", 64'(cyc), 64'd23);
        @(negedge clk1);
        check_val("post-abort word1", 64'(mem_o[1]), 64'h85E8_1354);

        // Start held mid-run is ignored; reset at WR0 stops the run
        start_run(1'b0, 1'b0, 64'd0, 9'd2);
        wait_cyc = 0;
        while (bus.blocks_done != 9'd1 && wait_cyc < 100) begin
            @(negedge clk1);
            wait_cyc++;
        end
        bus.start = 1'b1;
        repeat (3) @(negedge clk1);
        bus.start = 1'b0;
        check_val("held start busy", 64'(bus.busy), 64'd1);
        check_val("held start blocks_done", 64'(bus.blocks_done), 64'd1);
        wait_cyc = 0;
        while (bus.ramO_we !== 1'b1 && wait_cyc < 100) begin
            @(negedge clk1);
            wait_cyc++;
        end
        check_val("reach WR0 addr", 64'(bus.ramO_addr), 64'd2);
        base = we_cnt;
        reset = 1'b1;
        @(negedge clk1);
        reset = 1'b0;
        check_val("mid reset busy", 64'(bus.busy), 64'd0);
        check_val("mid reset done", 64'(bus.done), 64'd0);
        check_val("mid reset ramO_we", 64'(bus.ramO_we), 64'd0);
        check_val("mid reset blocks_done", 64'(bus.blocks_done), 64'd0);
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk1);
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        check_val("mid reset quiet", 64'(seen_done), 64'd0);
        check_val("mid reset writes", 64'(we_cnt - base), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
